// File: rtl/timer_reg_if.sv
// Bus-slave register block for the 8-bit timer counter: LOAD/CTRL/STATUS/COUNT registers,
// sticky interrupt-pending flag on interrupt-state entry, clear pulse and masked IRQ.
module timer_reg_if #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter logic [1:0]  INT_STATE = 2'b10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              S_sel,
    input  logic              S_wr,
    input  logic [ADDR_W-1:0] S_addr,
    input  logic [DATA_W-1:0] S_din,
    output logic [DATA_W-1:0] S_dout,
    input  logic [1:0]        cnt_state_in,
    input  logic [DATA_W-1:0] cnt_value_in,
    output logic              CNT_EN,
    output logic              CNT_CON,
    output logic [DATA_W-1:0] LOAD_VALUE,
    output logic              int_clear,
    output logic              o_irq
);

    localparam logic [ADDR_W-1:0] ADDR_LOAD   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_COUNT  = ADDR_W'(3);

    logic [DATA_W-1:0] load_q;
    logic [DATA_W-1:0] count_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] rdata;
    logic [2:0]        ctrl_q;
    logic [1:0]        state_q;
    logic              pending_q;
    logic              pending_d;
    logic              int_clear_q;
    logic              irq_q;
    logic              wr_en;
    logic              rd_en;
    logic              clr_req;
    logic              int_entry;

    assign wr_en     = S_sel & S_wr;
    assign rd_en     = S_sel & ~S_wr;
    assign clr_req   = wr_en && (S_addr == ADDR_STATUS) && S_din[0];
    assign int_entry = (state_q != INT_STATE) && (cnt_state_in == INT_STATE);

    always_comb begin
        rdata = '0;
        case (S_addr)
            ADDR_LOAD:   rdata = load_q;
            ADDR_CTRL:   rdata = DATA_W'(ctrl_q);
            ADDR_STATUS: rdata = DATA_W'({state_q, pending_q});
            ADDR_COUNT:  rdata = count_q;
            default:     rdata = '0;
        endcase
    end

    // Entry into the interrupt state beats a same-cycle software clear.
    always_comb begin
        pending_d = pending_q;
        if (int_entry) begin
            pending_d = 1'b1;
        end else if (clr_req) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_q      <= '0;
            ctrl_q      <= '0;
            pending_q   <= 1'b0;
            state_q     <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            int_clear_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_en && (S_addr == ADDR_LOAD)) begin
                load_q <= S_din;
            end
            if (wr_en && (S_addr == ADDR_CTRL)) begin
                ctrl_q <= S_din[2:0];
            end
            pending_q   <= pending_d;
            state_q     <= cnt_state_in;
            count_q     <= cnt_value_in;
            dout_q      <= rd_en ? rdata : '0;
            int_clear_q <= clr_req;
            irq_q       <= pending_q & ctrl_q[2];
        end
    end

    assign S_dout     = dout_q;
    assign CNT_EN     = ctrl_q[0];
    assign CNT_CON    = ctrl_q[1];
    assign LOAD_VALUE = load_q;
    assign int_clear  = int_clear_q;
    assign o_irq      = irq_q;

endmodule

// File: tb/tb_timer_reg_if.sv
// Self-checking bench for timer_reg_if: directed scenarios driven through a small counter
// emulator, then randomized bus/snoop traffic, all checked against a register-file model.
module tb_timer_reg_if;

    logic       clk;
    logic       reset_n;
    logic       S_sel;
    logic       S_wr;
    logic [2:0] S_addr;
    logic [7:0] S_din;
    logic [7:0] S_dout;
    logic [1:0] cnt_state_in;
    logic [7:0] cnt_value_in;
    logic       CNT_EN;
    logic       CNT_CON;
    logic [7:0] LOAD_VALUE;
    logic       int_clear;
    logic       o_irq;

    int checks = 0;
    int errors = 0;

    timer_reg_if #(
        .DATA_W    (8),
        .ADDR_W    (3),
        .INT_STATE (2'b10)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .S_sel        (S_sel),
        .S_wr         (S_wr),
        .S_addr       (S_addr),
        .S_din        (S_din),
        .S_dout       (S_dout),
        .cnt_state_in (cnt_state_in),
        .cnt_value_in (cnt_value_in),
        .CNT_EN       (CNT_EN),
        .CNT_CON      (CNT_CON),
        .LOAD_VALUE   (LOAD_VALUE),
        .int_clear    (int_clear),
        .o_irq        (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter emulator (IDLE=00, COUNT=01, INT=10) used to produce realistic snoop inputs.
    logic       use_ctr;
    logic [1:0] rnd_state;
    logic [7:0] rnd_value;
    logic [1:0] c_state;
    logic [1:0] c_ns;
    logic [7:0] c_count;
    logic [7:0] c_nc;

    always_comb begin
        c_ns = c_state;
        c_nc = c_count;
        case (c_state)
            2'b00: if (CNT_EN && LOAD_VALUE != 8'd0) begin c_ns = 2'b01; c_nc = LOAD_VALUE; end
            2'b01: begin
                if (!CNT_EN) begin
                    c_ns = 2'b00; c_nc = 8'd0;
                end else if (c_count <= 8'd1) begin
                    c_ns = 2'b10; c_nc = 8'd0;
                end else begin
                    c_nc = c_count - 8'd1;
                end
            end
            2'b10: if (int_clear) begin
                if (CNT_CON) begin c_ns = 2'b01; c_nc = LOAD_VALUE; end
                else begin c_ns = 2'b00; c_nc = 8'd0; end
            end
            default: c_ns = 2'b00;
        endcase
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_state <= 2'b00;
            c_count <= 8'd0;
        end else begin
            c_state <= c_ns;
            c_count <= c_nc;
        end
    end

    assign cnt_state_in = use_ctr ? c_ns : rnd_state;
    assign cnt_value_in = use_ctr ? c_nc : rnd_value;

    // Reference model: software-visible registers plus the observed output values.
    logic [7:0] m_reg [4];  // LOAD, CTRL, (STATUS built on read), COUNT
    logic       m_pend;
    logic [1:0] m_state;
    logic [7:0] m_dout;
    logic       m_clr;
    logic       m_irq;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_pend = 1'b0; m_state = 2'b00; m_dout = 8'h00; m_clr = 1'b0; m_irq = 1'b0;
    endtask

    function automatic logic [7:0] model_read(input logic [2:0] addr);
        if (addr == 3'd2) return {5'b0, m_state, m_pend};
        if (addr > 3'd3)  return 8'h00;
        return m_reg[addr[1:0]];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("s_dout",     S_dout,            m_dout);
        chk("cnt_en",     {7'b0, CNT_EN},    {7'b0, m_reg[1][0]});
        chk("cnt_con",    {7'b0, CNT_CON},   {7'b0, m_reg[1][1]});
        chk("load_value", LOAD_VALUE,        m_reg[0]);
        chk("int_clear",  {7'b0, int_clear}, {7'b0, m_clr});
        chk("o_irq",      {7'b0, o_irq},     {7'b0, m_irq});
    endtask

    // One bus cycle: drive, sample snoop inputs mid-cycle, clock, update model, check.
    task automatic step(input logic sel, input logic wr, input logic [2:0] addr,
                        input logic [7:0] din);
        logic [1:0] cs;
        logic [7:0] cv;
        logic       w;
        logic       entry;
        S_sel = sel; S_wr = wr; S_addr = addr; S_din = din;
        @(negedge clk);
        cs = cnt_state_in;
        cv = cnt_value_in;
        @(posedge clk);
        w      = sel & wr;
        entry  = (cs == 2'b10) && (m_state != 2'b10);
        m_dout = (sel && !wr) ? model_read(addr) : 8'h00;
        m_irq  = m_pend & m_reg[1][2];
        m_clr  = w && addr == 3'd2 && din[0];
        m_pend = entry ? 1'b1 : (m_clr ? 1'b0 : m_pend);
        if (w && addr == 3'd0) m_reg[0] = din;
        if (w && addr == 3'd1) m_reg[1] = din & 8'h07;
        m_state  = cs;
        m_reg[3] = cv;
        #1;
        chk_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    task automatic wait_int(input string tag);
        int n = 0;
        while (m_state != 2'b10 && n < 40) begin
            idle();
            n++;
        end
        chk(tag, {7'b0, (n < 40)}, 8'h01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; S_sel = 1'b0; S_wr = 1'b0; S_addr = 3'd0; S_din = 8'h00;
        use_ctr = 1'b1; rnd_state = 2'b00; rnd_value = 8'h00;
        model_reset();
        #12;
        reset_n = 1'b1;
        chk_outputs();

        // Reset values read back from every address.
        for (int a = 0; a < 8; a++) begin
            step(1'b1, 1'b0, 3'(a), 8'h00);
            chk("rst_read", S_dout, 8'h00);
        end

        // One-shot countdown into the interrupt state.
        step(1'b1, 1'b1, 3'd0, 8'h05);
        step(1'b1, 1'b1, 3'd1, 8'h05);
        idle();
        step(1'b1, 1'b0, 3'd2, 8'h00);
        chk("status_counting", S_dout, 8'h02);
        wait_int("reach_int_oneshot");
        idle();
        chk("irq_after_entry", {7'b0, o_irq}, 8'h01);
        step(1'b1, 1'b0, 3'd2, 8'h00);
        chk("status_int", S_dout, 8'h05);
        step(1'b1, 1'b0, 3'd3, 8'h00);
        chk("count_zero", S_dout, 8'h00);

        // Clear with CON=0: counter drops back to IDLE.
        step(1'b1, 1'b1, 3'd2, 8'h01);
        chk("clr_pulse", {7'b0, int_clear}, 8'h01);
        idle();
        chk("clr_pulse_end", {7'b0, int_clear}, 8'h00);
        chk("irq_fall", {7'b0, o_irq}, 8'h00);
        step(1'b1, 1'b0, 3'd2, 8'h00);
        chk("status_idle", S_dout, 8'h00);

        // Clear with CON=1: counter reloads.
        step(1'b1, 1'b1, 3'd1, 8'h07);
        idle();
        wait_int("reach_int_cont");
        idle();
        step(1'b1, 1'b1, 3'd2, 8'h01);
        idle();
        step(1'b1, 1'b0, 3'd3, 8'h00);
        chk("count_reload", S_dout, 8'h05);
        step(1'b1, 1'b0, 3'd2, 8'h00);
        chk("status_reload", S_dout, 8'h02);

        // Clear issued on the interrupt-entry edge: set must win.
        use_ctr = 1'b0; rnd_state = 2'b00; rnd_value = 8'h00;
        step(1'b1, 1'b1, 3'd1, 8'h04);
        idle();
        rnd_state = 2'b10; idle();
        rnd_state = 2'b01; idle();
        rnd_state = 2'b10;
        step(1'b1, 1'b1, 3'd2, 8'h01);
        chk("simul_clr_pulse", {7'b0, int_clear}, 8'h01);
        idle();
        chk("simul_irq_held", {7'b0, o_irq}, 8'h01);
        step(1'b1, 1'b0, 3'd2, 8'h00);
        chk("simul_pending", S_dout, 8'h05);

        // Masking INT_EN drops the IRQ but keeps pending.
        step(1'b1, 1'b1, 3'd1, 8'hF8);
        idle();
        chk("mask_irq", {7'b0, o_irq}, 8'h00);
        step(1'b1, 1'b0, 3'd2, 8'h00);
        chk("mask_pending", S_dout, 8'h05);
        step(1'b1, 1'b1, 3'd1, 8'h04);
        idle();
        chk("unmask_irq", {7'b0, o_irq}, 8'h01);

        // Asynchronous reset in the middle of a long count.
        use_ctr = 1'b1;
        step(1'b1, 1'b1, 3'd0, 8'hFF);
        step(1'b1, 1'b1, 3'd1, 8'h01);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'd3, 8'h00);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk_outputs();
        @(posedge clk);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 12; i++) idle();
        step(1'b1, 1'b0, 3'd2, 8'h00);
        chk("post_reset_status", S_dout, 8'h00);
        chk("post_reset_irq", {7'b0, o_irq}, 8'h00);

        // Randomized bus traffic with arbitrary snoop inputs.
        use_ctr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rnd_state = 2'($urandom_range(0, 3));
            rnd_value = 8'($urandom);
            step(($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom_range(0, 7)),
                 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_reg_if.md
Name: timer_reg_if

Overview:
- Bus-slave register interface that sits directly upstream of the 8-bit timer counter.
- Holds the software-visible LOAD and CTRL registers, which drive CNT_EN, CNT_CON and LOAD_VALUE into the counter.
- Watches the counter's next-state and next-count outputs and latches a sticky interrupt-pending flag.
- Produces the one-cycle int_clear pulse and a masked interrupt request.

Parameters:
- DATA_W, 8, bus data width and load/count width (fixed to 8 for the current counter).
- ADDR_W, 3, register address width; addresses 0-3 decoded, 4-7 reserved.
- INT_STATE, 2'b10, counter state encoding that means "interrupt".

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- S_sel  in  1  slave select, one-cycle access strobe.
- S_wr  in  1  1 = write, 0 = read (qualified by S_sel).
- S_addr  in  ADDR_W  register address.
- S_din  in  DATA_W  write data.
- S_dout  out  DATA_W  registered read data.
- cnt_state_in  in  2  from counter NEXT_counter_state.
- cnt_value_in  in  DATA_W  from counter NEXT_COUNT_VALUE.
- CNT_EN  out  1  counter enable (CTRL[0]).
- CNT_CON  out  1  continuous/reload mode (CTRL[1]).
- LOAD_VALUE  out  DATA_W  reload value (LOAD register).
- int_clear  out  1  one-cycle clear pulse to counter.
- o_irq  out  1  interrupt request (pending AND CTRL[2]).

Behaviour:
- Reset: asynchronous on reset_n low; takes effect immediately, including mid-access or mid-count. All registers and outputs go to 0: LOAD, CTRL, pending, state_q, count_q, S_dout, int_clear, o_irq.
- Register map:
  - 0 LOAD: R/W, [7:0].
  - 1 CTRL: R/W, bit0 CNT_EN, bit1 CNT_CON, bit2 INT_EN, bits[7:3] read 0 and ignore writes.
  - 2 STATUS: bit0 pending (R, write-1-clears), bits[2:1] state_q (RO), rest 0.
  - 3 COUNT: RO count_q.
  - 4-7: read 0, writes ignored.
- Writes: take effect on the clock edge where S_sel=1 and S_wr=1. CNT_EN, CNT_CON and LOAD_VALUE are direct register outputs, so the new value is visible the cycle after the write.
- Reads: S_sel=1, S_wr=0 at edge N puts data on S_dout after edge N, i.e. one-cycle latency. In cycles without a read, S_dout = 0.
- Snoop registers: state_q and count_q capture cnt_state_in and cnt_value_in every edge, mirroring the counter's internal state and count.
- Pending set: on the edge where state_q != INT_STATE and cnt_state_in == INT_STATE (entry edge detection only). Remaining in the interrupt state does not re-set pending.
- Pending clear: write to STATUS with S_din[0]=1 clears pending at that edge. Writing 0 has no effect.
- int_clear: registered. It is 1 for exactly the one cycle after a STATUS write with S_din[0]=1, regardless of the pending value, and 0 otherwise.
  - The counter samples int_clear at the following edge: it returns to IDLE if CNT_CON=0, or reloads to COUNT if CNT_CON=1.
- Simultaneous set and clear in one cycle: set wins, so pending stays 1; int_clear still pulses.
- o_irq: registered, equal to pending AND INT_EN, with one-cycle lag from both pending and INT_EN.
  - Clearing INT_EN masks o_irq but leaves pending intact.
- Back-to-back accesses: one access per cycle is supported with no wait states. A read of STATUS in the cycle after a clear write returns pending=0.
- Counter interaction: LOAD_VALUE=0 with CNT_EN=1 keeps the counter in IDLE. The block takes no special action in that case.

Test Plan:
- Reset then read addresses 0-7: every S_dout = 0x00; CNT_EN, CNT_CON, LOAD_VALUE, int_clear and o_irq all 0.
- Write LOAD=0x05, then CTRL=0x05 (EN=1, INT_EN=1, CON=0):
  - STATUS state bits go 01, then 10 after the countdown.
  - pending=1 and o_irq=1 one cycle later.
  - COUNT reads 0x00.
- With pending=1, write STATUS=0x01:
  - int_clear is high for exactly 1 cycle.
  - pending=0 and o_irq falls next cycle.
  - state_q returns to 00.
  - Repeat with CTRL=0x07 (CON=1): state_q returns to 01 and COUNT reloads to 0x05.
- Issue the STATUS clear write on the same edge as interrupt-state entry: pending remains 1, int_clear pulses, o_irq stays 1.
- With pending=1, write CTRL INT_EN=0: o_irq drops in 1 cycle while STATUS bit0 still reads 1. Re-enabling raises o_irq again.
- Assert reset_n mid-count (LOAD=0xFF, EN=1): all outputs go 0 asynchronously, and after release no interrupt occurs until reprogrammed.
